// File: rtl/sys_bus_regs_pkg.sv
// Shared definitions for the system-bus register slave: register offsets,
// FSM state encoding, decoded-access record and the offset decoder.
// Ports: none (package).
package sys_bus_regs_pkg;

  localparam logic [31:0] STS_OFS = 32'h0F0;
  localparam logic [31:0] CMT_OFS = 32'h0F4;
  localparam logic [31:0] ID_OFS  = 32'h0FC;

  typedef enum logic {S_IDLE, S_RESP} state_e;

  typedef enum logic [2:0] {K_CTL, K_STS, K_CMT, K_ID, K_BAD} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [5:0] idx;   // CTL word index; meaningful only for K_CTL
  } acc_t;

  // Classify an already-masked byte offset. CTL words occupy 0..4*nr-1,
  // which stays below STS_OFS for every legal nr (<= 48).
  function automatic acc_t decode(input logic [31:0] ofs, input int unsigned nr);
    acc_t a;
    a.kind = K_BAD;
    a.idx  = ofs[7:2];
    if (ofs[1:0] == 2'b00) begin
      if (ofs < (nr << 2))      a.kind = K_CTL;
      else if (ofs == STS_OFS)  a.kind = K_STS;
      else if (ofs == CMT_OFS)  a.kind = K_CMT;
      else if (ofs == ID_OFS)   a.kind = K_ID;
    end
    return a;
  endfunction

endpackage

// File: rtl/sys_bus_if.sv
// System bus point-to-point link between interconnect port and slave.
// Ports: addr/wdata/wen/ren (master -> slave), rdata/err/ack (slave -> master).
interface sys_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        err;
  logic        ack;

  modport s (input addr, wdata, wen, ren, output rdata, err, ack);
  modport m (output addr, wdata, wen, ren, input rdata, err, ack);
endinterface

// File: rtl/sys_bus_regs_sticky.sv
// NS-bit sticky event register: events set bits, write-1 clears them, and a
// set arriving in the same cycle as a clear on the same bit wins.
// Ports: clk_i, rst_i (sync, active high), set_i, clr_i, sts_o.
module sys_bus_regs_sticky #(
  parameter int NS = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [NS-1:0] set_i,
  input  logic [NS-1:0] clr_i,
  output logic [NS-1:0] sts_o
);

  logic [NS-1:0] sts_q, sts_d;

  always_comb sts_d = (sts_q & ~clr_i) | set_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) sts_q <= '0;
    else       sts_q <= sts_d;
  end

  assign sts_o = sts_q;

endmodule

// File: rtl/sys_bus_regs_slave.sv
// Register-bank responder: CTL bank, sticky STS, COMMIT and read-only ID,
// each access acknowledged with a registered one-cycle response.
// Ports: clk_i, rst_i, bus (sys_bus_if.s), ctl_o, evt_i, commit_o.
// Build option SYS_BUS_REGS_SHADOW_EN: CTL writes land in shadow registers
// and reach ctl_o only on a COMMIT write; undefined, CTL writes go straight
// to ctl_o and COMMIT only pulses commit_o.
import sys_bus_regs_pkg::*;

module sys_bus_regs_slave #(
  parameter int                     NR      = 8,
  parameter int                     NS      = 16,
  parameter int                     SW      = 20,
  parameter logic [31:0]            ID      = 32'h0,
  parameter logic [NR-1:0][31:0]    RST_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sys_bus_if.s                  bus,
  output logic [NR-1:0][31:0]   ctl_o,
  input  logic [NS-1:0]         evt_i,
  output logic                  commit_o
);

  localparam logic [31:0] OFS_MASK = (SW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << SW) - 32'd1);

  state_e              state_q, state_d;
  acc_t                acc;
  logic [31:0]         ofs;
  logic [NR-1:0][31:0] ctl_q;
  logic [NR-1:0][31:0] rd_src;
  logic [NR-1:0]       ctl_we;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                cmt_q, cmt_d;
  logic [NS-1:0]       clr;
  logic [NS-1:0]       sts;
  logic [31:0]         sts_ext;

  // Upper address bits belong to the interconnect's slot select.
  assign ofs = bus.addr & OFS_MASK;
  assign acc = decode(ofs, NR);

`ifdef SYS_BUS_REGS_SHADOW_EN
  logic [NR-1:0][31:0] shd_q;
  assign rd_src = shd_q;
`else
  assign rd_src = ctl_q;
`endif

  sys_bus_regs_sticky #(.NS(NS)) u_sticky (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .set_i (evt_i),
    .clr_i (clr),
    .sts_o (sts)
  );

  always_comb begin
    sts_ext = '0;
    sts_ext[NS-1:0] = sts;
  end

  // Any request, including an erroring one, earns exactly one ack next cycle.
  always_comb begin
    state_d = S_IDLE;
    if (bus.wen || bus.ren) state_d = S_RESP;
  end

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    cmt_d   = 1'b0;
    ctl_we  = '0;
    clr     = '0;
    if (bus.wen && bus.ren) begin
      err_d = 1'b1;
    end else if (bus.wen) begin
      case (acc.kind)
        K_CTL: begin
          for (int i = 0; i < NR; i++)
            if (acc.idx == 6'(i)) ctl_we[i] = 1'b1;
        end
        K_STS:   clr   = bus.wdata[NS-1:0];
        K_CMT:   cmt_d = 1'b1;
        default: err_d = 1'b1;
      endcase
    end else if (bus.ren) begin
      case (acc.kind)
        K_CTL: begin
          for (int i = 0; i < NR; i++)
            if (acc.idx == 6'(i)) rdata_d = rd_src[i];
        end
        K_STS:   rdata_d = sts_ext;
        K_ID:    rdata_d = ID;
        default: err_d   = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cmt_q   <= 1'b0;
      ctl_q   <= RST_VAL;
`ifdef SYS_BUS_REGS_SHADOW_EN
      shd_q   <= RST_VAL;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cmt_q   <= cmt_d;
`ifdef SYS_BUS_REGS_SHADOW_EN
      for (int i = 0; i < NR; i++)
        if (ctl_we[i]) shd_q[i] <= bus.wdata;
      // A CTL write never coincides with a commit, so shd_q here is settled.
      if (cmt_d) ctl_q <= shd_q;
`else
      for (int i = 0; i < NR; i++)
        if (ctl_we[i]) ctl_q[i] <= bus.wdata;
`endif
    end
  end

  assign bus.ack   = (state_q == S_RESP);
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign ctl_o     = ctl_q;
  assign commit_o  = cmt_q;

endmodule

// File: tb/tb_sys_bus_regs_slave.sv
module tb_sys_bus_regs_slave;
  import sys_bus_regs_pkg::*;

  localparam int          NR  = 8;
  localparam int          NS  = 16;
  localparam logic [31:0] IDV = 32'hCAFE0001;
  localparam logic [NR-1:0][31:0] RV = {32'h1007, 32'h1006, 32'h1005, 32'h1004,
                                        32'h1003, 32'h1002, 32'h1001, 32'h0000_0005};
`ifdef SYS_BUS_REGS_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_i;
  logic [NR-1:0][31:0] ctl_o;
  logic [NS-1:0]       evt_i;
  logic                commit_o;

  sys_bus_if bus_if ();

  sys_bus_regs_slave #(.NR(NR), .NS(NS), .SW(20), .ID(IDV), .RST_VAL(RV)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .bus      (bus_if),
    .ctl_o    (ctl_o),
    .evt_i    (evt_i),
    .commit_o (commit_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock and check the response that the previous cycle's
  // request (if any) should have produced.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus_if.ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_ack: got ack=1 expected ack=0");
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_err"},   {31'd0, bus_if.err}, {31'd0, e.err});
        chk({e.name, "_rdata"}, bus_if.rdata, e.rdata);
      end
    end else begin
      if (exp_q.size() != 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_ack %s: got ack=%b expected ack=1", exp_q[0].name, bus_if.ack);
        exp_q.delete();
      end
      chk("idle_rdata", bus_if.rdata, 32'h0);
    end
  endtask

  task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input string nm, input logic e_err, input logic [31:0] e_rd);
    exp_t x;
    bus_if.wen   = w;
    bus_if.ren   = r;
    bus_if.addr  = a;
    bus_if.wdata = d;
    x.name  = nm;
    x.err   = e_err;
    x.rdata = e_rd;
    exp_q.push_back(x);
    tick();
    bus_if.wen = 1'b0;
    bus_if.ren = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    issue(1'b1, 1'b0, a, d, nm, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input string nm, input logic [31:0] e_rd);
    issue(1'b0, 1'b1, a, 32'h0, nm, 1'b0, e_rd);
  endtask

  task automatic chk_ctl_rst(input string nm);
    for (int i = 0; i < NR; i++) chk($sformatf("%s_ctl%0d", nm, i), ctl_o[i], RV[i]);
  endtask

  vec_t tbl[14];

  initial begin
    rst_i        = 1'b1;
    evt_i        = '0;
    bus_if.wen   = 1'b0;
    bus_if.ren   = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    tick();
    tick();
    rst_i = 1'b0;

    // Reset state
    chk_ctl_rst("reset");
    chk("reset_commit", {31'd0, commit_o}, 32'h0);
    chk("reset_ack",    {31'd0, bus_if.ack}, 32'h0);
    chk("reset_err",    {31'd0, bus_if.err}, 32'h0);

    //           wen   ren   addr           wdata          err   rdata
    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0005};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_00FC, 32'h0,         1'b0, IDV};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_001C, 32'h0,         1'b0, 32'h0000_1007};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_00F8, 32'h0,         1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h1,         1'b1, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000_0002, 32'h0,         1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_00F4, 32'h0,         1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         1'b1, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_00F0, 32'h0,         1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         1'b0, 32'h1234_5678};
    tbl[12] = '{1'b0, 1'b1, 32'h0010_0008, 32'h0,         1'b0, 32'h1234_5678};
    tbl[13] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0005};

    for (int i = 0; i < 14; i++) begin
      issue(tbl[i].wen, tbl[i].ren, tbl[i].addr, tbl[i].wdata,
            $sformatf("vec%0d", i), tbl[i].err, tbl[i].rdata);
      tick();
    end
    chk("err_ctl0_kept", ctl_o[0], 32'h5);
    chk("ctl2_after_wr", ctl_o[2], SHADOW ? 32'h1002 : 32'h1234_5678);

    // Shadow / commit
    wr(32'h004, 32'hA5, "wr_ctl1");
    chk("ctl1_pre_commit", ctl_o[1], SHADOW ? 32'h1001 : 32'hA5);
    chk("commit_idle", {31'd0, commit_o}, 32'h0);
    wr(32'h0F4, 32'h0, "commit");
    chk("ctl1_post_commit", ctl_o[1], 32'hA5);
    chk("ctl2_post_commit", ctl_o[2], 32'h1234_5678);
    chk("commit_pulse", {31'd0, commit_o}, 32'h1);
    tick();
    chk("commit_one_cycle", {31'd0, commit_o}, 32'h0);
    wr(32'h004, 32'h77, "wr_ctl1_after");
    chk("ctl1_after_commit_wr", ctl_o[1], SHADOW ? 32'hA5 : 32'h77);
    rd(32'h004, "rd_ctl1_shadow", 32'h77);
    tick();

    // Sticky status
    evt_i = 16'h0008;
    tick();
    evt_i = '0;
    rd(32'h0F0, "sts_set", 32'h8);
    evt_i = 16'h0008;
    wr(32'h0F0, 32'h8, "w1c_vs_set");
    evt_i = '0;
    rd(32'h0F0, "sts_set_wins", 32'h8);
    wr(32'h0F0, 32'h8, "w1c_clear");
    rd(32'h0F0, "sts_cleared", 32'h0);
    evt_i = 16'h8001;
    tick();
    evt_i = '0;
    rd(32'h0F0, "sts_multi", 32'h8001);
    wr(32'h0F0, 32'h0001, "w1c_partial");
    rd(32'h0F0, "sts_partial", 32'h8000);
    tick();

    // Back-to-back writes then reads, one ack per cycle
    for (int i = 0; i < 4; i++) wr(32'(4 * i), 32'hB0 + 32'(i), $sformatf("b2b_wr%0d", i));
    for (int i = 0; i < 4; i++) rd(32'(4 * i), $sformatf("b2b_rd%0d", i), 32'hB0 + 32'(i));
    tick();
    wr(32'h0F4, 32'h0, "commit2");
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_ctl%0d", i), ctl_o[i], 32'hB0 + 32'(i));
    tick();

    // Reset in the same cycle as a read: request dropped, no ack
    evt_i = 16'h0020;
    tick();
    evt_i = '0;
    bus_if.ren  = 1'b1;
    bus_if.addr = 32'h0FC;
    rst_i       = 1'b1;
    tick();
    chk("rst_no_ack", {31'd0, bus_if.ack}, 32'h0);
    chk("rst_err",    {31'd0, bus_if.err}, 32'h0);
    chk("rst_commit", {31'd0, commit_o}, 32'h0);
    chk_ctl_rst("midrst");
    bus_if.ren = 1'b0;
    rst_i      = 1'b0;
    tick();
    rd(32'h0FC, "post_rst_id", IDV);
    rd(32'h0F0, "post_rst_sts", 32'h0);
    rd(32'h000, "post_rst_ctl0", 32'h5);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
